// File: rtl/pb_uart_io.sv
// pb_uart_io: 8N1 UART peripheral on the PicoBlaze port bus.
// Registers: BASE+0 DATA (TX push / RX pop), BASE+1 STATUS, BASE+2 CTRL.
// Optional feature macro: PB_UART_IO_LOOPBACK_EN (CTRL bit2 loops TX into RX).
//
// state   | meaning (TX and RX engines)
// S_IDLE  | line idle; TX waits for FIFO data, RX waits for falling edge
// S_START | start bit in progress
// S_DATA  | 8 data bits, LSB first
// S_STOP  | stop bit
module pb_uart_io #(
  parameter logic [7:0] BASE_ADDR    = 8'h00,
  parameter int         CLKS_PER_BIT = 434,
  parameter int         FIFO_DEPTH   = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] port_id,
  input  logic [7:0] out_port,
  input  logic       write_strobe,
  input  logic       read_strobe,
  output logic [7:0] in_port,
  output logic       interrupt,
  input  logic       interrupt_ack,
  input  logic       uart_rx,
  output logic       uart_tx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW+1)'(FIFO_DEPTH);
  localparam logic [7:0] ADDR_DATA = BASE_ADDR;
  localparam logic [7:0] ADDR_STAT = BASE_ADDR + 8'd1;
  localparam logic [7:0] ADDR_CTRL = BASE_ADDR + 8'd2;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_e;

  logic wr_data, wr_ctrl, rd_data, rd_stat;
  assign wr_data = write_strobe && (port_id == ADDR_DATA);
  assign wr_ctrl = write_strobe && (port_id == ADDR_CTRL);
  assign rd_data = read_strobe  && (port_id == ADDR_DATA);
  assign rd_stat = read_strobe  && (port_id == ADDR_STAT);

  // ---------------- FIFOs ----------------
  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [AW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [AW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [AW:0]   tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic tx_push, tx_pop, tx_full, tx_empty;
  logic rx_push, rx_pop, rx_full, rx_empty, overrun_set;

  uart_state_e   tx_state_q, rx_state_q;
  logic [CW-1:0] tx_cnt_bit_q, rx_cnt_bit_q;
  logic [2:0]    tx_idx_q, rx_idx_q;
  logic [7:0]    tx_sh_q, rx_sh_q;
  logic          tx_line_q, rx_push_q, rx_ferr_q;

  assign tx_full  = (tx_cnt_q == FULL_CNT);
  assign tx_empty = (tx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == FULL_CNT);
  assign rx_empty = (rx_cnt_q == '0);

  // A full FIFO still accepts a push when a pop happens in the same cycle
  assign tx_pop      = (tx_state_q == S_IDLE) && !tx_empty;
  assign tx_push     = wr_data && (!tx_full || tx_pop);
  assign rx_pop      = rd_data && !rx_empty;
  assign rx_push     = rx_push_q && (!rx_full || rx_pop);
  assign overrun_set = rx_push_q && rx_full && !rx_pop;

  // Next-state pointers and occupancy for both FIFOs
  always_comb begin
    tx_wp_d  = tx_wp_q + AW'(tx_push);
    tx_rp_d  = tx_rp_q + AW'(tx_pop);
    tx_cnt_d = tx_cnt_q + (AW+1)'(tx_push) - (AW+1)'(tx_pop);
    rx_wp_d  = rx_wp_q + AW'(rx_push);
    rx_rp_d  = rx_rp_q + AW'(rx_pop);
    rx_cnt_d = rx_cnt_q + (AW+1)'(rx_push) - (AW+1)'(rx_pop);
  end

  // FIFO storage; contents need no reset since occupancy gates every read
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp_q] <= out_port;
    if (rx_push) rx_mem[rx_wp_q] <= rx_sh_q;
  end

  // ---------------- TX engine ----------------
  // Single-process TX FSM with registered serial output
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q   <= S_IDLE;
      tx_cnt_bit_q <= '0;
      tx_idx_q     <= '0;
      tx_sh_q      <= '0;
      tx_line_q    <= 1'b1;
    end else begin
      case (tx_state_q)
        S_IDLE: begin
          tx_line_q <= 1'b1;
          if (!tx_empty) begin
            tx_sh_q      <= tx_mem[tx_rp_q];
            tx_line_q    <= 1'b0;
            tx_cnt_bit_q <= BIT_LAST;
            tx_state_q   <= S_START;
          end
        end
        S_START: begin
          if (tx_cnt_bit_q == '0) begin
            tx_line_q    <= tx_sh_q[0];
            tx_cnt_bit_q <= BIT_LAST;
            tx_idx_q     <= '0;
            tx_state_q   <= S_DATA;
          end else tx_cnt_bit_q <= tx_cnt_bit_q - CW'(1);
        end
        S_DATA: begin
          if (tx_cnt_bit_q == '0) begin
            tx_cnt_bit_q <= BIT_LAST;
            if (tx_idx_q == 3'd7) begin
              tx_line_q  <= 1'b1;
              tx_state_q <= S_STOP;
            end else begin
              tx_sh_q   <= {1'b0, tx_sh_q[7:1]};
              tx_line_q <= tx_sh_q[1];
              tx_idx_q  <= tx_idx_q + 3'd1;
            end
          end else tx_cnt_bit_q <= tx_cnt_bit_q - CW'(1);
        end
        S_STOP: begin
          if (tx_cnt_bit_q == '0) tx_state_q <= S_IDLE;
          else tx_cnt_bit_q <= tx_cnt_bit_q - CW'(1);
        end
        default: tx_state_q <= S_IDLE;
      endcase
    end
  end

  // ---------------- RX engine ----------------
  logic [2:0] ctrl_q, ctrl_d;
  logic rx_src, rx_meta_q, rx_sync_q, rx_prev_q;

`ifdef PB_UART_IO_LOOPBACK_EN
  assign rx_src = ctrl_q[2] ? tx_line_q : uart_rx;
`else
  assign rx_src = uart_rx;
`endif

  // Two-flop synchroniser plus one delayed copy for falling-edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_src;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // Single-process RX FSM; rx_push_q / rx_ferr_q are one-cycle event pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state_q   <= S_IDLE;
      rx_cnt_bit_q <= '0;
      rx_idx_q     <= '0;
      rx_sh_q      <= '0;
      rx_push_q    <= 1'b0;
      rx_ferr_q    <= 1'b0;
    end else begin
      rx_push_q <= 1'b0;
      rx_ferr_q <= 1'b0;
      case (rx_state_q)
        S_IDLE: begin
          if (rx_prev_q && !rx_sync_q) begin
            rx_cnt_bit_q <= HALF_LAST;
            rx_state_q   <= S_START;
          end
        end
        S_START: begin
          if (rx_cnt_bit_q == '0) begin
            if (rx_sync_q) rx_state_q <= S_IDLE;
            else begin
              rx_cnt_bit_q <= BIT_LAST;
              rx_idx_q     <= '0;
              rx_state_q   <= S_DATA;
            end
          end else rx_cnt_bit_q <= rx_cnt_bit_q - CW'(1);
        end
        S_DATA: begin
          if (rx_cnt_bit_q == '0) begin
            rx_sh_q      <= {rx_sync_q, rx_sh_q[7:1]};
            rx_cnt_bit_q <= BIT_LAST;
            if (rx_idx_q == 3'd7) rx_state_q <= S_STOP;
            else rx_idx_q <= rx_idx_q + 3'd1;
          end else rx_cnt_bit_q <= rx_cnt_bit_q - CW'(1);
        end
        S_STOP: begin
          if (rx_cnt_bit_q == '0) begin
            if (rx_sync_q) rx_push_q <= 1'b1;
            else rx_ferr_q <= 1'b1;
            rx_state_q <= S_IDLE;
          end else rx_cnt_bit_q <= rx_cnt_bit_q - CW'(1);
        end
        default: rx_state_q <= S_IDLE;
      endcase
    end
  end

  // ---------------- Registers, read mux, interrupt ----------------
  logic       overrun_q, overrun_d, ferr_q, ferr_d;
  logic       cond_q, pend_q, pend_d, irq_cond, tx_busy;
  logic [7:0] in_port_q, in_port_d, status;

  assign tx_busy = (tx_state_q != S_IDLE);

  // Sticky status, CTRL write, interrupt edge capture and read-data decode
  always_comb begin
    ctrl_d = ctrl_q;
    if (wr_ctrl) begin
`ifdef PB_UART_IO_LOOPBACK_EN
      ctrl_d = out_port[2:0];
`else
      ctrl_d = {1'b0, out_port[1:0]};
`endif
    end
    overrun_d = overrun_set | (overrun_q & ~rd_stat);
    ferr_d    = rx_ferr_q   | (ferr_q & ~rd_stat);
    irq_cond  = (ctrl_q[0] & ~rx_empty) | (ctrl_q[1] & tx_empty);
    pend_d    = (irq_cond & ~cond_q) | (pend_q & ~interrupt_ack);
    status    = {1'b0, ferr_q, overrun_q, tx_busy, tx_empty, tx_full, rx_full, ~rx_empty};
    in_port_d = 8'h00;
    if (port_id == ADDR_DATA)      in_port_d = rx_empty ? 8'h00 : rx_mem[rx_rp_q];
    else if (port_id == ADDR_STAT) in_port_d = status;
    else if (port_id == ADDR_CTRL) in_port_d = {5'b0, ctrl_q};
  end

  // State register for FIFO pointers and control/status flops
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_wp_q   <= '0;
      tx_rp_q   <= '0;
      tx_cnt_q  <= '0;
      rx_wp_q   <= '0;
      rx_rp_q   <= '0;
      rx_cnt_q  <= '0;
      ctrl_q    <= '0;
      overrun_q <= 1'b0;
      ferr_q    <= 1'b0;
      cond_q    <= 1'b0;
      pend_q    <= 1'b0;
      in_port_q <= 8'h00;
    end else begin
      tx_wp_q   <= tx_wp_d;
      tx_rp_q   <= tx_rp_d;
      tx_cnt_q  <= tx_cnt_d;
      rx_wp_q   <= rx_wp_d;
      rx_rp_q   <= rx_rp_d;
      rx_cnt_q  <= rx_cnt_d;
      ctrl_q    <= ctrl_d;
      overrun_q <= overrun_d;
      ferr_q    <= ferr_d;
      cond_q    <= irq_cond;
      pend_q    <= pend_d;
      in_port_q <= in_port_d;
    end
  end

  assign in_port   = in_port_q;
  assign interrupt = pend_q;
  assign uart_tx   = tx_line_q;

endmodule

// File: tb/tb_pb_uart_io.sv
// Testbench for pb_uart_io with CLKS_PER_BIT=16, BASE_ADDR=8'h00.
module tb_pb_uart_io;
  localparam int C = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] port_id = 8'h00;
  logic [7:0] out_port = 8'h00;
  logic       write_strobe = 1'b0;
  logic       read_strobe = 1'b0;
  logic       interrupt_ack = 1'b0;
  logic       uart_rx = 1'b1;
  logic [7:0] in_port;
  logic       interrupt;
  logic       uart_tx;

  int errors = 0;
  int checks = 0;
  logic [7:0] rx_exp_q[$];
  logic [7:0] tx_exp_q[$];

  pb_uart_io #(.BASE_ADDR(8'h00), .CLKS_PER_BIT(C), .FIFO_DEPTH(16)) dut (
    .clk(clk), .reset(reset), .port_id(port_id), .out_port(out_port),
    .write_strobe(write_strobe), .read_strobe(read_strobe), .in_port(in_port),
    .interrupt(interrupt), .interrupt_ack(interrupt_ack),
    .uart_rx(uart_rx), .uart_tx(uart_tx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", tag, act, exp);
    end
  endtask

  task automatic io_write(input logic [7:0] addr, input logic [7:0] data);
    @(negedge clk);
    port_id = addr; out_port = data; write_strobe = 1'b1;
    @(negedge clk);
    write_strobe = 1'b0;
  endtask

  task automatic io_read(input logic [7:0] addr, output logic [7:0] data);
    @(negedge clk);
    port_id = addr;
    @(negedge clk);
    read_strobe = 1'b1;
    data = in_port;
    @(negedge clk);
    read_strobe = 1'b0;
  endtask

  task automatic read_check(input logic [7:0] addr, input logic [7:0] exp, input string tag);
    logic [7:0] d;
    io_read(addr, d);
    check(tag, d, exp);
  endtask

  // DATA read compared against the scoreboard head; an empty scoreboard expects 8'h00
  task automatic read_data_sb(input string tag);
    logic [7:0] d;
    logic [7:0] exp;
    io_read(8'h00, d);
    exp = (rx_exp_q.size() != 0) ? rx_exp_q.pop_front() : 8'h00;
    check(tag, d, exp);
  endtask

  task automatic send_serial(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (C) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (C) @(negedge clk);
    end
    uart_rx = stop_bit;
    repeat (C) @(negedge clk);
    uart_rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic [7:0] exp_b;
    logic [7:0] cap;
    logic [7:0] b;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_in_port", in_port, 8'h00);
    check("rst_uart_tx", uart_tx, 1'b1);
    check("rst_interrupt", interrupt, 1'b0);
    read_check(8'h01, 8'h08, "rst_status");
    read_check(8'h02, 8'h00, "rst_ctrl");
    read_check(8'h03, 8'h00, "bad_addr");
    read_data_sb("empty_data");

    // TX frame of 8'hA5 with start latency and mid-bit sampling
    tx_exp_q.push_back(8'hA5);
    @(negedge clk);
    port_id = 8'h00; out_port = 8'hA5; write_strobe = 1'b1;
    @(negedge clk);
    write_strobe = 1'b0;
    check("tx_lat1", uart_tx, 1'b1);
    @(negedge clk);
    check("tx_start_edge", uart_tx, 1'b0);
    repeat (7) @(negedge clk);
    check("tx_start_mid", uart_tx, 1'b0);
    io_read(8'h01, d);
    check("tx_busy_status", d, 8'h18);
    exp_b = tx_exp_q.pop_front();
    repeat (C - 3) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      if (i != 0) repeat (C) @(negedge clk);
      cap[i] = uart_tx;
      check($sformatf("tx_bit%0d", i), uart_tx, exp_b[i]);
    end
    check("tx_byte", cap, exp_b);
    repeat (C) @(negedge clk);
    check("tx_stop", uart_tx, 1'b1);
    repeat (C + 4) @(negedge clk);
    read_check(8'h01, 8'h08, "tx_done_status");

    // Reset in the middle of a frame (8'h3C has bit1=0 on the line)
    io_write(8'h00, 8'h3C);
    repeat (40) @(negedge clk);
    check("pre_rst_tx", uart_tx, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_tx", uart_tx, 1'b1);
    reset = 1'b0;
    repeat (3 * C) @(negedge clk);
    check("rst_mid_idle", uart_tx, 1'b1);
    read_check(8'h01, 8'h08, "rst_mid_status");

    // Single RX byte
    rx_exp_q.push_back(8'h3C);
    send_serial(8'h3C, 1'b1);
    read_check(8'h01, 8'h09, "rx_status");
    read_data_sb("rx_data");
    read_check(8'h01, 8'h08, "rx_status_after");

    // Framing error: byte discarded, sticky bit cleared by STATUS read
    send_serial(8'hF0, 1'b0);
    read_check(8'h01, 8'h48, "ferr_status");
    read_check(8'h01, 8'h08, "ferr_clear");

    // Overrun: 17 bytes into a 16-deep FIFO
    for (int i = 0; i < 17; i++) begin
      b = 8'(i * 37 + 5);
      if (i < 16) rx_exp_q.push_back(b);
      send_serial(b, 1'b1);
    end
    read_check(8'h01, 8'h2B, "ovr_status");
    read_check(8'h01, 8'h0B, "ovr_clear");
    for (int i = 0; i < 16; i++) read_data_sb($sformatf("ovr_data%0d", i));
    read_check(8'h01, 8'h08, "ovr_drained");

    // RX interrupt: raised once, held until ack, not re-raised by a second byte
    io_write(8'h02, 8'h01);
    repeat (2) @(negedge clk);
    check("irq_idle", interrupt, 1'b0);
    rx_exp_q.push_back(8'h55);
    send_serial(8'h55, 1'b1);
    check("irq_set", interrupt, 1'b1);
    repeat (20) @(negedge clk);
    check("irq_hold", interrupt, 1'b1);
    interrupt_ack = 1'b1;
    @(negedge clk);
    interrupt_ack = 1'b0;
    check("irq_ack", interrupt, 1'b0);
    rx_exp_q.push_back(8'h66);
    send_serial(8'h66, 1'b1);
    check("irq_no_rearm", interrupt, 1'b0);
    read_data_sb("irq_data0");
    read_data_sb("irq_data1");
    io_write(8'h02, 8'h00);

`ifdef PB_UART_IO_LOOPBACK_EN
    io_write(8'h02, 8'h04);
    read_check(8'h02, 8'h04, "ctrl_lb");
    rx_exp_q.push_back(8'h7E);
    io_write(8'h00, 8'h7E);
    repeat (12 * C) @(negedge clk);
    read_data_sb("lb_data");
    io_write(8'h02, 8'h00);
`else
    io_write(8'h02, 8'h04);
    read_check(8'h02, 8'h00, "ctrl_no_lb");
`endif

    check("sb_empty", 8'(rx_exp_q.size()), 8'h00);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
